pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request to resolve one instruction; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2: 00 sequential, 01 beq, 10 bne, 11 jump.
REQ-006 SHALL have port imm, input, 12: branch word offset (signed) or jump word target.
REQ-007 SHALL have port R, input, 1: result from the 16-bit comparator.
REQ-008 SHALL have port cmpeq, output, 1: comparator equal-test select.
REQ-009 SHALL have port cmpne, output, 1: comparator not-equal-test select.
REQ-010 SHALL have port pc, output, 16: current program counter.
REQ-011 SHALL have port busy, output, 1: high while a request is in progress (not IDLE).
REQ-012 SHALL have port done, output, 1: one-cycle pulse; new pc is valid in the same cycle.
REQ-013 SHALL have port taken, output, 1: whether the last resolved instruction redirected the PC; valid with done, held until the next done.

Function
REQ-014 SHALL use states IDLE, CMP and UPDATE.
REQ-015 SHALL, in IDLE with start=1, latch op and imm and go to CMP if op is 01/10, else to UPDATE.
REQ-016 SHALL go CMP -> UPDATE unconditionally, sampling R into taken at the end of CMP.
REQ-017 SHALL go UPDATE -> IDLE unconditionally, writing pc and asserting done in the following cycle.
REQ-018 SHALL drive cmpeq=1 only in CMP with latched op 01, and cmpne=1 only in CMP with latched op 10; both SHALL be 0 otherwise and SHALL never be high together.
REQ-019 SHALL compute next pc as follows (all 16-bit, wrap-around, no overflow flag):
- sequential: pc+2.
- beq/bne taken: pc+2+(sext(imm)<<1).
- beq/bne not taken: pc+2.
- jump: {pc[15:13], imm, 1'b0}.
REQ-020 SHALL set taken=1 for jump and taken=0 for sequential.
REQ-021 SHALL have a latency from the start-sampling edge to done of 3 cycles for beq/bne and 2 cycles for sequential/jump.
REQ-022 SHALL ignore start while busy=1; changes to op, imm or start during busy SHALL NOT affect the result.
REQ-023 SHALL accept start in the same cycle done is high, since the FSM is already in IDLE then.
REQ-024 SHALL wrap pc from 16'hFFFE to 16'h0000 on sequential.
REQ-025 SHALL wrap negative offsets modulo 2^16.
REQ-026 SHALL sample R only at the end of CMP and SHALL ignore R at all other times.

Reset
REQ-027 SHALL, on rst_n=0, immediately set pc=RESET_PC, state=IDLE, and set busy, done, taken, cmpeq and cmpne to 0, including mid-operation.
REQ-028 SHALL NOT complete or commit any PC update for an aborted request after reset.
REQ-029 SHALL, after rst_n rises, accept start on the first rising edge.

Structure
REQ-030 SHALL take its op encodings (OP_SEQ, OP_BEQ, OP_BNE, OP_JMP) and state encodings from shared package proc_pkg.
REQ-031 SHALL place next-PC arithmetic in one combinational sub-module, next_pc_calc (inputs: pc, op, imm, taken; output: next pc).

Verification
REQ-032 Reset then sequential: rst_n low->high, start op=00 -> done two cycles after start, pc=0002, taken=0, cmpeq=cmpne=0 throughout.
REQ-033 beq taken: pc=0010, op=01, imm=12'h004, R=1 during CMP -> cmpeq=1 for exactly one cycle, done at +3, pc=001A, taken=1.
REQ-034 bne not taken and negative offset:
- pc=0010, op=10, imm=12'hFFE, R=0 -> cmpne pulses, pc=0012, taken=0.
- Repeat with R=1 -> pc=000E.
REQ-035 Jump and wrap:
- pc=A000, op=11, imm=12'h123 -> pc=A246, taken=1.
- Then pc=FFFE, op=00 -> pc=0000.
REQ-036 Busy/ignore and reset abort:
- Second start and changes to imm during CMP -> result unchanged.
- rst_n low during UPDATE -> pc=RESET_PC at once, no done pulse.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode and FSM state encodings for the PC/branch resolution logic.
package proc_pkg;

    localparam logic [1:0] OP_SEQ = 2'b00;
    localparam logic [1:0] OP_BEQ = 2'b01;
    localparam logic [1:0] OP_BNE = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCmp    = 2'b01,
        StUpdate = 2'b10
    } state_t;

    function automatic logic is_branch(input logic [1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic: sequential, PC-relative branch and region jump.
module next_pc_calc
    import proc_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [1:0]  op,
    input  logic [11:0] imm,
    input  logic        taken,
    output logic [15:0] next_pc
);

    logic [15:0] seq_pc;
    logic [15:0] br_off;

    assign seq_pc = pc + 16'd2;
    // Word offset: sign-extend and scale to bytes.
    assign br_off = {{3{imm[11]}}, imm, 1'b0};

    always_comb begin
        next_pc = seq_pc;
        if (op == OP_JMP) begin
            next_pc = {pc[15:13], imm, 1'b0};
        end else if (is_branch(op) && taken) begin
            next_pc = seq_pc + br_off;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with a small FSM that resolves one sequential/branch/jump request at a time.
module pc_branch_unit
    import proc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [11:0] imm,
    input  logic        R,
    output logic        cmpeq,
    output logic        cmpne,
    output logic [15:0] pc,
    output logic        busy,
    output logic        done,
    output logic        taken
);

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [11:0] imm_q;
    logic        r_q;
    logic [15:0] pc_q;
    logic        taken_q;
    logic        done_q;
    logic        take;
    logic [15:0] next_pc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = is_branch(op) ? StCmp : StUpdate;
            StCmp:    state_d = StUpdate;
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // r_q only matters for branches, and every branch passes through CMP first.
    assign take = (op_q == OP_JMP) || (is_branch(op_q) && r_q);

    next_pc_calc u_next_pc_calc (
        .pc      (pc_q),
        .op      (op_q),
        .imm     (imm_q),
        .taken   (take),
        .next_pc (next_pc)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_SEQ;
            imm_q   <= '0;
            r_q     <= 1'b0;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StUpdate);
            if (state_q == StIdle && start) begin
                op_q  <= op;
                imm_q <= imm;
            end
            if (state_q == StCmp) begin
                r_q <= R;
            end
            // The visible taken flag only moves together with pc and done.
            if (state_q == StUpdate) begin
                pc_q    <= next_pc;
                taken_q <= take;
            end
        end
    end

    assign cmpeq = (state_q == StCmp) && (op_q == OP_BEQ);
    assign cmpne = (state_q == StCmp) && (op_q == OP_BNE);
    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign pc    = pc_q;
    assign taken = taken_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table, corner sequences, random ops.
module tb_pc_branch_unit;

    localparam logic [15:0] RST_PC = 16'h0040;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [11:0] imm = 12'h000;
    logic        R = 1'b0;
    logic        cmpeq, cmpne, busy, done, taken;
    logic [15:0] pc;

    pc_branch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .imm   (imm),
        .R     (R),
        .cmpeq (cmpeq),
        .cmpne (cmpne),
        .pc    (pc),
        .busy  (busy),
        .done  (done),
        .taken (taken)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int model_pc;
    bit model_taken;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] imm;
        logic        r;
        logic [15:0] pc;
        logic        tk;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference next PC from plain integer arithmetic.
    function automatic int ref_next(input int p, input bit [1:0] o, input bit [11:0] im,
                                    input bit t);
        int off;
        off = int'(im);
        if (off >= 2048) off -= 4096;
        if (o == 2'b11) return (p / 8192) * 8192 + int'(im) * 2;
        if ((o == 2'b01 || o == 2'b10) && t) return ((p + 2 + off * 2) % 65536 + 65536) % 65536;
        return (p + 2) % 65536;
    endfunction

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic run_op(input bit [1:0] o, input bit [11:0] im, input bit rv, input string tag);
        int lat = 0;
        int neq = 0;
        int nne = 0;
        bit both = 0;
        bit busy_ok = 1;
        bit hold_ok = 1;
        bit exp_t;
        int exp_p;
        exp_t = (o == 2'b11) ? 1'b1 : (o == 2'b00) ? 1'b0 : rv;
        exp_p = ref_next(model_pc, o, im, exp_t);
        start = 1'b1;
        op    = o;
        imm   = im;
        R     = 1'($urandom);
        for (int e = 1; e <= 6 && lat == 0; e++) begin
            @(posedge CLK);
            @(negedge CLK);
            neq += int'(cmpeq);
            nne += int'(cmpne);
            if (cmpeq && cmpne) both = 1;
            if (done) begin
                lat   = e;
                start = 1'b0;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (pc !== model_pc[15:0] || taken !== model_taken) hold_ok = 0;
                // Comparator answer for the CMP cycle; everything else is noise.
                R     = (e == 1) ? rv : 1'($urandom);
                start = 1'($urandom);
                op    = 2'($urandom);
                imm   = 12'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, (o == 2'b01 || o == 2'b10) ? 3 : 2);
        chk({tag, ".pc"}, int'(pc), exp_p);
        chk({tag, ".taken"}, int'(taken), int'(exp_t));
        chk({tag, ".cmpeq_cycles"}, neq, (o == 2'b01) ? 1 : 0);
        chk({tag, ".cmpne_cycles"}, nne, (o == 2'b10) ? 1 : 0);
        chk({tag, ".cmp_both"}, int'(both), 0);
        chk({tag, ".busy"}, int'(busy_ok), 1);
        chk({tag, ".hold"}, int'(hold_ok), 1);
        model_pc    = exp_p;
        model_taken = exp_t;
    endtask

    // Walk upward 0x1000 per taken branch until the region matches, then jump in.
    task automatic goto_pc(input logic [15:0] target);
        logic [15:0] mp;
        mp = model_pc[15:0];
        while (mp[15:13] != target[15:13]) begin
            run_op(2'b01, 12'h7FF, 1'b1, "goto.br");
            mp = model_pc[15:0];
        end
        run_op(2'b11, target[12:1], 1'b0, "goto.jmp");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit no_done;
        vecs[0] = '{2'b00, 12'h000, 1'b0, 16'h0042, 1'b0};
        vecs[1] = '{2'b11, 12'h008, 1'b0, 16'h0010, 1'b1};
        vecs[2] = '{2'b01, 12'h004, 1'b1, 16'h001A, 1'b1};
        vecs[3] = '{2'b11, 12'h008, 1'b0, 16'h0010, 1'b1};
        vecs[4] = '{2'b10, 12'hFFE, 1'b0, 16'h0012, 1'b0};
        vecs[5] = '{2'b11, 12'h008, 1'b0, 16'h0010, 1'b1};
        vecs[6] = '{2'b10, 12'hFFE, 1'b1, 16'h000E, 1'b1};
        vecs[7] = '{2'b01, 12'h7FF, 1'b0, 16'h0010, 1'b0};
        vecs[8] = '{2'b01, 12'h7FF, 1'b1, 16'h1010, 1'b1};
        vecs[9] = '{2'b00, 12'h000, 1'b0, 16'h1012, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset.pc", int'(pc), int'(RST_PC));
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.taken", int'(taken), 0);
        chk("reset.cmpeq", int'(cmpeq), 0);
        chk("reset.cmpne", int'(cmpne), 0);
        @(negedge CLK);
        @(negedge CLK);
        rst_n       = 1'b1;
        model_pc    = int'(RST_PC);
        model_taken = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].imm, vecs[i].r, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.table_pc", i), int'(pc), int'(vecs[i].pc));
            chk($sformatf("vec%0d.table_taken", i), int'(taken), int'(vecs[i].tk));
        end

        goto_pc(16'hA000);
        run_op(2'b11, 12'h123, 1'b0, "jump_a000");
        chk("jump_a000.abs_pc", int'(pc), 16'hA246);
        goto_pc(16'hFFFE);
        run_op(2'b00, 12'h000, 1'b0, "wrap");
        chk("wrap.abs_pc", int'(pc), 0);

        for (int i = 0; i < 150; i++) begin
            run_op(2'($urandom), 12'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
            if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge CLK);
        end

        // Reset while in CMP: comparator selects drop at once.
        run_op(2'b11, 12'h008, 1'b0, "pre_abort");
        start = 1'b1; op = 2'b01; imm = 12'h004; R = 1'b1;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0;
        chk("abort_cmp.cmpeq_before", int'(cmpeq), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cmp.cmpeq", int'(cmpeq), 0);
        chk("abort_cmp.busy", int'(busy), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        model_pc = int'(RST_PC);
        model_taken = 1'b0;

        // Reset while in UPDATE: no commit, no done.
        run_op(2'b11, 12'h008, 1'b0, "pre_abort2");
        start = 1'b1; op = 2'b01; imm = 12'h004; R = 1'b1;
        @(posedge CLK); @(negedge CLK);
        start = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("abort_upd.busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_upd.pc", int'(pc), int'(RST_PC));
        chk("abort_upd.taken", int'(taken), 0);
        chk("abort_upd.busy", int'(busy), 0);
        no_done = 1;
        repeat (3) begin
            @(posedge CLK); @(negedge CLK);
            if (done !== 1'b0 || pc !== RST_PC) no_done = 0;
        end
        chk("abort_upd.no_commit", int'(no_done), 1);
        rst_n = 1'b1;
        model_pc = int'(RST_PC);
        model_taken = 1'b0;
        run_op(2'b00, 12'h000, 1'b0, "after_reset");
        chk("after_reset.abs_pc", int'(pc), int'(RST_PC) + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
